// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, handshake FSM states and result flags.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_NAND = 4'd5,
    OP_NOR  = 4'd6,
    OP_XOR  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
    logic err;
  } flags_t;

  // Two's-complement overflow; subtraction is addition of the inverted subtrahend sign.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb, input logic is_sub);
    logic b_eff;
    b_eff = is_sub ? ~b_msb : b_msb;
    return (a_msb == b_eff) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the register-read stage, the ALU and writeback.
interface alu_seq_if #(
  parameter int WIDTH = 8
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [3:0]           op;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   r;
  logic                 c;
  logic                 z;
  logic                 n;
  logic                 v;
  logic                 err;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, r, c, z, n, v, err
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, r, c, z, n, v, err
  );

endinterface

// File: rtl/alu_seq_mul.sv
// Radix-2 shift-add unsigned multiplier: fixed WIDTH-cycle latency, one partial product per cycle.
module alu_mul_shiftadd #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;

  // Multiplier datapath and down-counter; done is a one-cycle pulse after the last step.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc    <= {(2*WIDTH){1'b0}};
      r_mcand  <= {(2*WIDTH){1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= {(2*WIDTH){1'b0}};
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= CNT_LAST;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
    end else if (r_busy) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end else begin
        r_acc <= r_acc;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt == {CW{1'b0}}) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_cnt  <= r_cnt - CW'(1);
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_prod = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: single-cycle add/sub/logic, WIDTH-cycle multiply, registered result+flags.
// Optional ALU_SHIFT_EN builds logical SHL/SHR; without it opcodes 8/9 take the illegal-op path.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
  localparam logic [2*WIDTH-1:0] ZERO_2W = {(2*WIDTH){1'b0}};

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  op_t                r_op;
  logic [2*WIDTH-1:0] r_res;
  flags_t             r_flags;

  logic               w_capture;
  logic               w_mul_start;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;
  logic               w_load_out;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_res;
  flags_t             w_flags;

  assign w_capture   = (r_state == IDLE) && bus.in_valid;
  assign w_mul_start = w_capture && (op_t'(bus.op) == OP_MUL);
  assign w_load_out  = (r_state == EXEC) || ((r_state == MUL) && w_mul_done);
  assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff      = {1'b0, r_a} - {1'b0, r_b};

`ifdef ALU_SHIFT_EN
  localparam int SHW = $clog2(WIDTH) + 1;
  logic [SHW-1:0] w_amt;
  assign w_amt = r_b[SHW-1:0];
`endif

  alu_mul_shiftadd #(.WIDTH(WIDTH)) u_mul (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (w_mul_start),
    .i_a     (bus.a),
    .i_b     (bus.b),
    .o_busy  (w_mul_busy),
    .o_done  (w_mul_done),
    .o_prod  (w_mul_prod)
  );

  // Handshake FSM next-state; MUL falls back to IDLE if the multiplier stops without finishing.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_next_state = (op_t'(bus.op) == OP_MUL) ? MUL : EXEC;
        end else begin
          w_next_state = IDLE;
        end
      end
      EXEC: w_next_state = DONE;
      MUL: begin
        if (w_mul_done) begin
          w_next_state = DONE;
        end else if (w_mul_busy) begin
          w_next_state = MUL;
        end else begin
          w_next_state = IDLE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Result and flag generation from the captured operands (or the finished product).
  always_comb begin
    w_res   = ZERO_2W;
    w_flags = flags_t'(5'b0);
    case (r_op)
      OP_ADD: begin
        w_res     = {{(WIDTH-1){1'b0}}, w_sum};
        w_flags.c = w_sum[WIDTH];
        w_flags.v = signed_ovf(r_a[WIDTH-1], r_b[WIDTH-1], w_sum[WIDTH-1], 1'b0);
      end
      OP_SUB: begin
        w_res     = {ZERO_W, w_diff[WIDTH-1:0]};
        w_flags.c = w_diff[WIDTH];
        w_flags.v = signed_ovf(r_a[WIDTH-1], r_b[WIDTH-1], w_diff[WIDTH-1], 1'b1);
      end
      OP_MUL:  w_res = w_mul_prod;
      OP_AND:  w_res = {ZERO_W, r_a & r_b};
      OP_OR:   w_res = {ZERO_W, r_a | r_b};
      OP_NAND: w_res = {ZERO_W, ~(r_a & r_b)};
      OP_NOR:  w_res = {ZERO_W, ~(r_a | r_b)};
      OP_XOR:  w_res = {ZERO_W, r_a ^ r_b};
`ifdef ALU_SHIFT_EN
      OP_SHL:  w_res = (int'(w_amt) >= WIDTH) ? ZERO_2W : ({ZERO_W, r_a} << w_amt);
      OP_SHR:  w_res = (int'(w_amt) >= WIDTH) ? ZERO_2W : {ZERO_W, r_a >> w_amt};
`endif
      default: w_flags.err = 1'b1;
    endcase
    w_flags.z = (w_res == ZERO_2W);
    w_flags.n = (r_op == OP_MUL) ? w_res[2*WIDTH-1] : w_res[WIDTH-1];
  end

  // State, operand capture and output registers; outputs only move on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= ZERO_W;
      r_b     <= ZERO_W;
      r_op    <= OP_ADD;
      r_res   <= ZERO_2W;
      r_flags <= flags_t'(5'b0);
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_a  <= bus.a;
        r_b  <= bus.b;
        r_op <= op_t'(bus.op);
      end
      if (w_load_out) begin
        r_res   <= w_res;
        r_flags <= w_flags;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.r         = r_res;
  assign bus.c         = r_flags.c;
  assign bus.z         = r_flags.z;
  assign bus.n         = r_flags.n;
  assign bus.v         = r_flags.v;
  assign bus.err       = r_flags.err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq (WIDTH=8) plus backpressure and mid-multiply reset sequences.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  op;
    logic [15:0] exp_r;
    logic [4:0]  exp_fl;   // {c,z,n,v,err}
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Issue one operation from IDLE, wait (bounded) for out_valid, sample, then take the result.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        output logic [15:0] r, output logic [4:0] fl, output int lat,
                        output logic leak);
    bus.a = a;
    bus.b = b;
    bus.op = op;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    leak = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready !== 1'b0) leak = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    r = bus.r;
    fl = {bus.c, bus.z, bus.n, bus.v, bus.err};
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    logic [4:0]  fl;
    int          lat;
    logic        leak;
    logic        ok_r;
    logic        ok_rdy;
    logic        ok_nv;

    vecs.push_back('{8'hFF, 8'h01, 4'd0, 16'h0100, 5'b10000, 1});
    vecs.push_back('{8'h7F, 8'h01, 4'd0, 16'h0080, 5'b00110, 1});
    vecs.push_back('{8'h80, 8'h80, 4'd0, 16'h0100, 5'b10010, 1});
    vecs.push_back('{8'h10, 8'h20, 4'd1, 16'h00F0, 5'b10100, 1});
    vecs.push_back('{8'h55, 8'h55, 4'd1, 16'h0000, 5'b01000, 1});
    vecs.push_back('{8'h80, 8'h01, 4'd1, 16'h007F, 5'b00010, 1});
    vecs.push_back('{8'hFF, 8'hFF, 4'd2, 16'hFE01, 5'b00100, 9});
    vecs.push_back('{8'h00, 8'h37, 4'd2, 16'h0000, 5'b01000, 9});
    vecs.push_back('{8'h0C, 8'h0D, 4'd2, 16'h009C, 5'b00000, 9});
    vecs.push_back('{8'hF0, 8'h3C, 4'd3, 16'h0030, 5'b00000, 1});
    vecs.push_back('{8'h0F, 8'h80, 4'd4, 16'h008F, 5'b00100, 1});
    vecs.push_back('{8'hAA, 8'h55, 4'd5, 16'h00FF, 5'b00100, 1});
    vecs.push_back('{8'hF0, 8'h01, 4'd6, 16'h000E, 5'b00000, 1});
    vecs.push_back('{8'hAA, 8'hAA, 4'd7, 16'h0000, 5'b01000, 1});
    vecs.push_back('{8'h12, 8'h34, 4'hF, 16'h0000, 5'b01001, 1});
    vecs.push_back('{8'h12, 8'h34, 4'hA, 16'h0000, 5'b01001, 1});
`ifdef ALU_SHIFT_EN
    vecs.push_back('{8'h81, 8'h01, 4'd8, 16'h0102, 5'b00000, 1});
    vecs.push_back('{8'h81, 8'h03, 4'd9, 16'h0010, 5'b00000, 1});
    vecs.push_back('{8'h81, 8'h08, 4'd8, 16'h0000, 5'b01000, 1});
    vecs.push_back('{8'h81, 8'h07, 4'd8, 16'h4080, 5'b00100, 1});
`else
    vecs.push_back('{8'h81, 8'h01, 4'd8, 16'h0000, 5'b01001, 1});
    vecs.push_back('{8'h81, 8'h03, 4'd9, 16'h0000, 5'b01001, 1});
`endif

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    bus.op = 4'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_r", 32'(bus.r), 32'd0);
    chk("rst_flags", 32'({bus.c, bus.z, bus.n, bus.v, bus.err}), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, r, fl, lat, leak);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_r", i), 32'(r), 32'(vecs[i].exp_r));
      chk($sformatf("v%0d_flags", i), 32'(fl), 32'(vecs[i].exp_fl));
      chk($sformatf("v%0d_busy_ready", i), 32'(leak), 32'd0);
    end

    // Backpressure: ADD 3+4 held in DONE for 10 cycles while a new request is presented.
    bus.a = 8'h03;
    bus.b = 8'h04;
    bus.op = 4'd0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    ok_r = 1'b1;
    ok_rdy = 1'b1;
    bus.a = 8'h09;
    bus.b = 8'h01;
    bus.op = 4'd1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.r !== 16'h0007 || bus.out_valid !== 1'b1) ok_r = 1'b0;
      if (bus.in_ready !== 1'b0) ok_rdy = 1'b0;
    end
    chk("bp_r_stable", 32'(ok_r), 32'd1);
    chk("bp_in_ready_low", 32'(ok_rdy), 32'd0 + 32'd1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_taken_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_taken_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_ignored_op", 32'(bus.out_valid), 32'd0);
    chk("bp_r_held", 32'(bus.r), 32'h0007);

    // Reset four cycles into a multiply discards it.
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    bus.op = 4'd2;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_r", 32'(bus.r), 32'd0);
    chk("mrst_flags", 32'({bus.c, bus.z, bus.n, bus.v, bus.err}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    ok_nv = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) ok_nv = 1'b0;
    end
    chk("mrst_no_stale_result", 32'(ok_nv), 32'd1);
    run_op(8'h20, 8'h05, 4'd0, r, fl, lat, leak);
    chk("mrst_next_lat", 32'(lat), 32'd1);
    chk("mrst_next_r", 32'(r), 32'h0025);
    chk("mrst_next_flags", 32'(fl), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
